// File: rtl/dmux_pkg.sv
// Shared constants for the 1-to-4 dispatcher: channel geometry and FSM state encoding.
package dmux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  // Channel after c, wrapping 3 -> 0.
  function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] c);
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/dmux4_dispatcher_rr_pick4.sv
// Rotating-priority search: first requesting channel at or after ptr (mod 4) wins.
// Combinational; grant falls back to ptr when nothing requests.
module rr_pick4
  import dmux_pkg::*;
(
  input  logic [CH_W-1:0]   ptr,
  input  logic [NUM_CH-1:0] req,
  output logic [CH_W-1:0]   grant,
  output logic              any
);

  logic [CH_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest requester is written last.
  always_comb begin
    grant = ptr;
    any   = 1'b0;
    cand  = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = ptr + CH_W'(i);
      if (req[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmux4_dispatcher.sv
// One-word holding dispatcher onto four consumers sharing out_data; 1-cycle accept-to-offer latency.
// Optional saturating per-channel transfer counters under `DMUX4_DISPATCH_CNT_EN (else cnt_flat = 0).
module dmux4_dispatcher
  import dmux_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [CH_W-1:0]        in_dest,
  output logic [WIDTH-1:0]       out_data,
  output logic [NUM_CH-1:0]      out_valid,
  input  logic [NUM_CH-1:0]      out_ready,
  output logic [CH_W-1:0]        sel,
  output logic                   busy,
  output logic [NUM_CH*COUNT_W-1:0] cnt_flat
);

  logic             state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CH_W-1:0]  rr_q, rr_d;

  logic             xfer;
  logic             accept;
  logic [CH_W-1:0]  scan_ptr;
  logic [CH_W-1:0]  rr_grant;
  logic             rr_any;
  logic [CH_W-1:0]  dest;

  assign xfer     = (state_q == ST_HOLD) && out_ready[sel_q];
  assign in_ready = !reset && ((state_q == ST_IDLE) || xfer);
  assign accept   = in_valid && in_ready;

  // A word accepted while the held one leaves must see the pointer as it will be after that transfer.
  assign scan_ptr = xfer ? ch_next(sel_q) : rr_q;

  rr_pick4 u_pick (
    .ptr   (scan_ptr),
    .req   (out_ready),
    .grant (rr_grant),
    .any   (rr_any)
  );

  assign dest = mode ? in_dest : (rr_any ? rr_grant : scan_ptr);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_HOLD;
      ST_HOLD: if (xfer && !in_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      data_d = in_data;
      sel_d  = dest;
    end
    if (xfer) rr_d = ch_next(sel_q);
  end

  // Output decode
  always_comb begin
    busy      = (state_q == ST_HOLD);
    sel       = sel_q;
    out_data  = data_q;
    out_valid = '0;
    if (state_q == ST_HOLD) out_valid = NUM_CH'(1) << sel_q;
  end

`ifdef DMUX4_DISPATCH_CNT_EN
  logic [COUNT_W-1:0] cnt_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else if (xfer && (cnt_q[sel_q] != {COUNT_W{1'b1}})) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int k = 0; k < NUM_CH; k++) cnt_flat[k*COUNT_W +: COUNT_W] = cnt_q[k];
  end
`else
  assign cnt_flat = '0;
`endif

endmodule
